// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage: fetch PC register plus the IF/ID
// pipeline register.
//
// The PC advances to next_pc on every unstalled cycle. The PC is redirected
// to the exception entry on req, or to epc on eret. Either redirect also
// flushes IF/ID with a bubble. A bubble still carries a valid PC, so a later
// interrupt on that bubble records the correct EPC.
//
// A fetch address error (AdEL) is detected on the current pc_f. When it
// occurs, the instruction word is replaced by a nop and the error code is
// passed to decode.
//
// Ports
//   clk       in   1   clock, rising edge
//   reset     in   1   synchronous, active-high
//   next_pc   in   32  next fetch address from the npc unit
//   stall     in   1   hold PC and IF/ID
//   req       in   1   exception/interrupt redirect to EXC_ENTRY, flush IF/ID
//   eret      in   1   return redirect to epc, flush IF/ID
//   epc       in   32  CP0 EPC value
//   bd_f      in   1   current fetch is a branch delay slot
//   im_rdata  in   32  instruction memory read data (combinational on im_addr)
//   im_addr   out  32  instruction memory address (= pc_f), combinational
//   pc_f      out  32  current fetch PC
//   pc4_f     out  32  pc_f + 4, combinational
//   instr_d   out  32  IF/ID instruction
//   pc_d      out  32  IF/ID PC
//   pc4_d     out  32  IF/ID PC + 4
//   exc_d     out  5   IF/ID ExcCode, 0 = none
//   bd_d      out  1   IF/ID delay-slot flag
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_END    = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        bd_f,
    input  logic [31:0] im_rdata,
    output logic [31:0] im_addr,
    output logic [31:0] pc_f,
    output logic [31:0] pc4_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc4_d,
    output logic [4:0]  exc_d,
    output logic        bd_d
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 5;

    // IF/ID payload, kept as one packed word so that a flush or a hold
    // acts on every field together.
    typedef struct packed {
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pc4;
        logic [EXC_W-1:0] exc;
        logic             bd;
    } ifid_t;

    logic [XLEN-1:0] pc_f_q;
    logic [XLEN-1:0] pc_f_d;
    ifid_t           ifid_q;
    ifid_t           ifid_d;

    logic [XLEN-1:0]  pc_plus4;
    logic             fetch_err;
    logic [XLEN-1:0]  fetch_instr;
    logic [EXC_W-1:0] fetch_exc;

    // PC + 4 uses 32-bit modulo arithmetic, so 0xFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc_f_q + XLEN'(4);

    // Fetch check: misaligned, or outside the instruction memory window.
    always_comb begin
        fetch_err   = 1'b0;
        fetch_instr = im_rdata;
        fetch_exc   = '0;
        if ((pc_f_q[1:0] != 2'b00) || (pc_f_q < IM_BASE) || (pc_f_q > IM_END)) begin
            fetch_err = 1'b1;
        end
        if (fetch_err) begin
            fetch_instr = '0;
            fetch_exc   = EXC_ADEL;
        end
    end

    // Next-state selection. Priority is req > eret > stall > advance.
    // Reset is applied in the register process.
    always_comb begin
        pc_f_d = pc_f_q;
        ifid_d = ifid_q;
        if (req) begin
            pc_f_d       = EXC_ENTRY;
            ifid_d.instr = '0;
            ifid_d.pc    = EXC_ENTRY;
            ifid_d.pc4   = EXC_ENTRY + XLEN'(4);
            ifid_d.exc   = '0;
            ifid_d.bd    = 1'b0;
        end else if (eret) begin
            // An eret has no delay slot, and it takes effect even while stalled.
            pc_f_d       = epc;
            ifid_d.instr = '0;
            ifid_d.pc    = epc;
            ifid_d.pc4   = epc + XLEN'(4);
            ifid_d.exc   = '0;
            ifid_d.bd    = 1'b0;
        end else if (!stall) begin
            pc_f_d       = next_pc;
            ifid_d.instr = fetch_instr;
            ifid_d.pc    = pc_f_q;
            ifid_d.pc4   = pc_plus4;
            ifid_d.exc   = fetch_exc;
            ifid_d.bd    = bd_f;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q       <= PC_RESET;
            ifid_q.instr <= '0;
            ifid_q.pc    <= PC_RESET;
            ifid_q.pc4   <= PC_RESET + XLEN'(4);
            ifid_q.exc   <= '0;
            ifid_q.bd    <= 1'b0;
        end else begin
            pc_f_q <= pc_f_d;
            ifid_q <= ifid_d;
        end
    end

    assign pc_f    = pc_f_q;
    assign im_addr = pc_f_q;
    assign pc4_f   = pc_plus4;
    assign instr_d = ifid_q.instr;
    assign pc_d    = ifid_q.pc;
    assign pc4_d   = ifid_q.pc4;
    assign exc_d   = ifid_q.exc;
    assign bd_d    = ifid_q.bd;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// Directed scenarios come first, followed by randomized cycles. Every output
// is compared after each edge against a reference model of the fetch stage.
// The instruction memory is a fixed function of the address.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_END    = 32'h0000_6FFC;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic        bd_f;
    logic [31:0] im_rdata;
    logic [31:0] im_addr;
    logic [31:0] pc_f;
    logic [31:0] pc4_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic [4:0]  exc_d;
    logic        bd_d;

    int n_checks;
    int n_fail;

    // Model state: the fetch PC and the contents expected in IF/ID.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4d;
    logic [31:0] m_exc;
    logic        m_bd;

    if_stage dut (
        .clk      (clk),
        .reset    (reset),
        .next_pc  (next_pc),
        .stall    (stall),
        .req      (req),
        .eret     (eret),
        .epc      (epc),
        .bd_f     (bd_f),
        .im_rdata (im_rdata),
        .im_addr  (im_addr),
        .pc_f     (pc_f),
        .pc4_f    (pc4_f),
        .instr_d  (instr_d),
        .pc_d     (pc_d),
        .pc4_d    (pc4_d),
        .exc_d    (exc_d),
        .bd_d     (bd_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign im_rdata = mem_word(im_addr);

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= IM_BASE) && (a <= IM_END);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model and compare every output.
    task automatic cyc(input logic rst, input logic st, input logic rq, input logic er,
                       input logic bd, input logic [31:0] npc, input logic [31:0] ep);
        @(negedge clk);
        reset   = rst;
        stall   = st;
        req     = rq;
        eret    = er;
        bd_f    = bd;
        next_pc = npc;
        epc     = ep;
        if (rst) begin
            m_pc = PC_RESET; m_instr = 0; m_pcd = PC_RESET; m_pc4d = PC_RESET + 4;
            m_exc = 0; m_bd = 0;
        end else if (rq) begin
            m_pc = EXC_ENTRY; m_instr = 0; m_pcd = EXC_ENTRY; m_pc4d = EXC_ENTRY + 4;
            m_exc = 0; m_bd = 0;
        end else if (er) begin
            m_pc = ep; m_instr = 0; m_pcd = ep; m_pc4d = ep + 4;
            m_exc = 0; m_bd = 0;
        end else if (!st) begin
            m_instr = legal(m_pc) ? mem_word(m_pc) : 32'h0;
            m_exc   = legal(m_pc) ? 32'd0 : 32'd4;
            m_pcd   = m_pc;
            m_pc4d  = m_pc + 4;
            m_bd    = bd;
            m_pc    = npc;
        end
        @(posedge clk);
        #1;
        chk("pc_f",    pc_f,    m_pc);
        chk("im_addr", im_addr, m_pc);
        chk("pc4_f",   pc4_f,   m_pc + 32'd4);
        chk("instr_d", instr_d, m_instr);
        chk("pc_d",    pc_d,    m_pcd);
        chk("pc4_d",   pc4_d,   m_pc4d);
        chk("exc_d",   32'(exc_d), m_exc);
        chk("bd_d",    32'(bd_d),  32'(m_bd));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; stall = 1'b0; req = 1'b0; eret = 1'b0;
        bd_f = 1'b0; next_pc = 32'h0; epc = 32'h0;
        m_pc = 0; m_instr = 0; m_pcd = 0; m_pc4d = 0; m_exc = 0; m_bd = 0;

        // Reset for two cycles, then run free.
        cyc(1, 0, 0, 0, 0, 32'h0, 32'h0);
        cyc(1, 0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, m_pc + 4, 32'h0);
        // Stall at 0x3010 while next_pc changes.
        chk("stall_start_pc", pc_f, 32'h0000_3010);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, $urandom, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0000_3002, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0000_2FFC, 32'h0);
        chk("adel_mis_exc", 32'(exc_d), 32'd4);
        cyc(0, 0, 0, 0, 0, 32'h0000_3000, 32'h0);
        chk("adel_low_pcd", pc_d, 32'h0000_2FFC);
        // req wins over stall and eret.
        cyc(0, 1, 1, 1, 1, 32'h0000_5000, 32'h0000_3024);
        // eret to 0x3024, then the fetch there.
        cyc(0, 0, 0, 1, 0, 32'h0, 32'h0000_3024);
        cyc(0, 0, 0, 0, 0, 32'h0000_3028, 32'h0);
        chk("eret_instr", instr_d, mem_word(32'h0000_3024));
        // Delay-slot flag on one edge, then cleared by req.
        cyc(0, 0, 0, 0, 1, 32'h0000_302C, 32'h0);
        chk("bd_set", 32'(bd_d), 32'd1);
        cyc(0, 0, 1, 0, 0, 32'h0000_3030, 32'h0);
        // Top of the window, then wrap of pc+4.
        cyc(0, 0, 0, 1, 0, 32'h0, IM_END);
        cyc(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0000_7000, 32'h0);
        chk("wrap_pc4d", pc4_d, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0000_3000, 32'h0);

        // Randomized cycles.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic [31:0] npc;
            logic [31:0] ep;
            r  = $urandom_range(0, 99);
            ep = (r < 50) ? (IM_BASE + ($urandom_range(0, 32'h0FFF) << 2)) : $urandom;
            case ($urandom_range(0, 9))
                0:       npc = $urandom;
                1:       npc = IM_BASE + $urandom_range(0, 32'h3FFF);
                2:       npc = IM_END + 32'd4;
                default: npc = m_pc + 4;
            endcase
            if (m_pc > IM_END || m_pc < IM_BASE) npc = IM_BASE + ($urandom_range(0, 32'h0FFF) << 2);
            cyc((r == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 24) == 0), ($urandom_range(0, 4) == 0), npc, ep);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
